clk_div_multi: RTL

//  Multi-channel programmable divider; successor of the fixed single-channel ripple divider.

---
 rtl/clk_div_pkg.sv | 21 ++
 rtl/clk_div_multi_if.sv | 28 ++
 rtl/clk_div_chan.sv | 59 +++++
 rtl/clk_div_multi.sv | 64 ++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel clock-enable divider.
package clk_div_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam int unsigned CW_DEFAULT      = 24;
    localparam int unsigned DEF_DIV_DEFAULT = 131072;

    // Per-channel configuration payload carried by a load.
    typedef struct packed {
        logic [CW_DEFAULT-1:0] div;
        logic                  mode;
    } chan_cfg_t;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/config inputs and divided outputs of the divider block.
interface clk_div_multi_if #(
    parameter int unsigned NCH = 2,
    parameter int unsigned CW  = clk_div_pkg::CW_DEFAULT
);
    localparam int unsigned LW = clk_div_pkg::idx_w(NCH);

    logic           en;
    logic           sync;
    logic           ld;
    logic [LW-1:0]  ld_ch;
    logic [CW-1:0]  ld_div;
    logic           ld_mode;
    logic           ld_err;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;

    modport master (
        output en, sync, ld, ld_ch, ld_div, ld_mode,
        input  ld_err, tick, sq
    );

    modport slave (
        input  en, sync, ld, ld_ch, ld_div, ld_mode,
        output ld_err, tick, sq
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: config registers, down-counter, tick and level outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CW       = CW_DEFAULT,
    parameter int unsigned DEF_DIV  = DEF_DIV_DEFAULT,
    parameter logic        DEF_MODE = MODE_TOGGLE
) (
    input  logic      ck,
    input  logic      rst_n,
    input  logic      en,
    input  logic      sync,
    input  logic      load,
    input  chan_cfg_t new_cfg,
    output logic      tick,
    output logic      sq
);

    logic [CW-1:0] div_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] new_div;
    logic          mode_q;

    assign new_div = CW'(new_cfg.div);

    // Load beats sync beats counting; the counter reloads at zero and never wraps.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= CW'(DEF_DIV);
            mode_q <= DEF_MODE;
            cnt_q  <= CW'(DEF_DIV - 1);
            tick   <= 1'b0;
            sq     <= 1'b0;
        end else if (load) begin
            div_q  <= new_div;
            mode_q <= new_cfg.mode;
            cnt_q  <= new_div - CW'(1);
            tick   <= 1'b0;
            sq     <= 1'b0;
        end else if (sync) begin
            cnt_q  <= div_q - CW'(1);
            tick   <= 1'b0;
            sq     <= 1'b0;
        end else if (en) begin
            if (cnt_q == '0) begin
                cnt_q <= div_q - CW'(1);
                tick  <= 1'b1;
                sq    <= (mode_q == MODE_TOGGLE) ? ~sq : 1'b1;
            end else begin
                cnt_q <= cnt_q - CW'(1);
                tick  <= 1'b0;
                sq    <= (mode_q == MODE_TOGGLE) ? sq : 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable divider producing per-channel clock enables.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter int unsigned CW       = CW_DEFAULT,
    parameter int unsigned DEF_DIV  = DEF_DIV_DEFAULT,
    parameter logic        DEF_MODE = MODE_TOGGLE
) (
    input  logic                ck,
    input  logic                rst_n,
    clk_div_multi_if.slave      bus
);

    localparam int unsigned LW = idx_w(NCH);

    logic           ld_ok;
    logic           ld_err_q;
    chan_cfg_t      ld_cfg;
    logic [NCH-1:0] tick_w;
    logic [NCH-1:0] sq_w;

    // A load is accepted only with a non-zero divisor and an existing channel.
    always_comb begin
        ld_ok       = 1'b0;
        ld_cfg.div  = CW_DEFAULT'(bus.ld_div);
        ld_cfg.mode = bus.ld_mode;
        if (bus.ld && (bus.ld_div != '0) && (32'(bus.ld_ch) < NCH)) begin
            ld_ok = 1'b1;
        end
    end

    // One channel instance per output bit, each addressed by its index.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_div_chan #(
            .CW       (CW),
            .DEF_DIV  (DEF_DIV),
            .DEF_MODE (DEF_MODE)
        ) u_chan (
            .ck      (ck),
            .rst_n   (rst_n),
            .en      (bus.en),
            .sync    (bus.sync),
            .load    (ld_ok && (bus.ld_ch == LW'(i))),
            .new_cfg (ld_cfg),
            .tick    (tick_w[i]),
            .sq      (sq_w[i])
        );
    end

    // Rejected-load flag, one cycle per rejected strobe.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            ld_err_q <= 1'b0;
        end else begin
            ld_err_q <= bus.ld && !ld_ok;
        end
    end

    assign bus.tick   = tick_w;
    assign bus.sq     = sq_w;
    assign bus.ld_err = ld_err_q;

endmodule
